wb_stage: RTL and testbench

- Write-back stage of the single-issue MIPS datapath: the writer end of the register-file port (drives regwrite, jal_ra, wr, write data).
- Accepts one retiring instruction per handshake from the MEM stage.
- Waits for load data from data memory when required, aligns and extends it, then issues exactly one one-cycle register write.
- Stalls upstream while a load is outstanding.

---
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: load wait/format and single-cycle register write (optional WB_FWD_EN bypass outputs)
module wb_stage #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         regwrite_in,
  input  logic         memtoreg_in,
  input  logic         jal_in,
  input  logic [4:0]   wr_in,
  input  logic [W-1:0] alu_result_in,
  input  logic [W-1:0] pc_plus4_in,
  input  logic [1:0]   load_size,
  input  logic         load_unsigned,
  input  logic         dmem_rvalid,
  input  logic [W-1:0] dmem_rdata,
  output logic         regwrite,
  output logic         jal_ra,
  output logic [4:0]   wr_out,
  output logic [W-1:0] write_data_out,
`ifdef WB_FWD_EN
  output logic         fwd_valid,
  output logic [4:0]   fwd_reg,
  output logic [W-1:0] fwd_data,
`endif
  output logic         stall
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  logic [1:0]   state;
  logic         transfer;

  // Load context held while data memory answers
  logic [4:0]   pend_wr;
  logic         pend_rw;
  logic [1:0]   pend_off;
  logic [1:0]   pend_size;
  logic         pend_uns;

  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [W-1:0] fmt_data;

  // Accept whenever not waiting on memory; never while reset is held
  always_comb begin
    in_ready = ~reset && (state != WAIT_MEM);
    stall    = ~in_ready;
    transfer = in_valid && in_ready;
  end

  // Align and extend returned load data using the captured offset and size
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    fmt_data = '0;
    case (pend_off)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    // addr[0] deliberately ignored: misaligned halves just take the enclosing half
    half_sel = pend_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (pend_size)
      2'b00:   fmt_data = pend_uns ? {{(W-8){1'b0}}, byte_sel}
                                   : {{(W-8){byte_sel[7]}}, byte_sel};
      2'b01:   fmt_data = pend_uns ? {{(W-16){1'b0}}, half_sel}
                                   : {{(W-16){half_sel[15]}}, half_sel};
      default: fmt_data = dmem_rdata;
    endcase
  end

  // FSM plus registered register-file write port
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      regwrite       <= 1'b0;
      jal_ra         <= 1'b0;
      wr_out         <= 5'd0;
      write_data_out <= '0;
      pend_wr        <= 5'd0;
      pend_rw        <= 1'b0;
      pend_off       <= 2'd0;
      pend_size      <= 2'd0;
      pend_uns       <= 1'b0;
    end else begin
      case (state)
        WAIT_MEM: begin
          if (dmem_rvalid) begin
            state          <= WRITE;
            write_data_out <= fmt_data;
            wr_out         <= pend_wr;
            jal_ra         <= 1'b0;
            regwrite       <= pend_rw && (pend_wr != 5'd0);
          end
        end
        default: begin
          // IDLE and WRITE share accept rules, giving back-to-back writes
          if (transfer) begin
            if (jal_in) begin
              state          <= WRITE;
              regwrite       <= 1'b1;
              jal_ra         <= 1'b1;
              wr_out         <= 5'd31;
              write_data_out <= pc_plus4_in;
            end else if (memtoreg_in) begin
              state     <= WAIT_MEM;
              regwrite  <= 1'b0;
              jal_ra    <= 1'b0;
              pend_wr   <= wr_in;
              pend_rw   <= regwrite_in;
              pend_off  <= alu_result_in[1:0];
              pend_size <= load_size;
              pend_uns  <= load_unsigned;
            end else begin
              state          <= WRITE;
              regwrite       <= regwrite_in && (wr_in != 5'd0);
              jal_ra         <= 1'b0;
              wr_out         <= wr_in;
              write_data_out <= alu_result_in;
            end
          end else begin
            state    <= IDLE;
            regwrite <= 1'b0;
            jal_ra   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef WB_FWD_EN
  // Bypass copy of the write port for decode-stage forwarding
  always_comb begin
    fwd_valid = regwrite;
    fwd_reg   = jal_ra ? 5'd31 : wr_out;
    fwd_data  = write_data_out;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         regwrite_in;
  logic         memtoreg_in;
  logic         jal_in;
  logic [4:0]   wr_in;
  logic [W-1:0] alu_result_in;
  logic [W-1:0] pc_plus4_in;
  logic [1:0]   load_size;
  logic         load_unsigned;
  logic         dmem_rvalid;
  logic [W-1:0] dmem_rdata;
  logic         regwrite;
  logic         jal_ra;
  logic [4:0]   wr_out;
  logic [W-1:0] write_data_out;
  logic         stall;
`ifdef WB_FWD_EN
  logic         fwd_valid;
  logic [4:0]   fwd_reg;
  logic [W-1:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  wb_stage #(.W(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .jal_in(jal_in),
    .wr_in(wr_in), .alu_result_in(alu_result_in), .pc_plus4_in(pc_plus4_in),
    .load_size(load_size), .load_unsigned(load_unsigned),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .regwrite(regwrite), .jal_ra(jal_ra), .wr_out(wr_out),
    .write_data_out(write_data_out),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
    .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    regwrite_in   = 1'b0;
    memtoreg_in   = 1'b0;
    jal_in        = 1'b0;
    wr_in         = 5'd0;
    alu_result_in = '0;
    pc_plus4_in   = '0;
    load_size     = 2'b00;
    load_unsigned = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic set_alu(input logic [4:0] wr, input logic [W-1:0] data);
    in_valid = 1'b1; regwrite_in = 1'b1; memtoreg_in = 1'b0; jal_in = 1'b0;
    wr_in = wr; alu_result_in = data;
  endtask

  task automatic set_load(input logic [4:0] wr, input logic [1:0] off,
                          input logic [1:0] size, input logic uns);
    in_valid = 1'b1; regwrite_in = 1'b1; memtoreg_in = 1'b1; jal_in = 1'b0;
    wr_in = wr; alu_result_in = {30'h0000_1000, off};
    load_size = size; load_unsigned = uns;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %0b want 0", regwrite); end
    tests++; if (jal_ra !== 1'b0) begin fails++; $display("FAIL reset_jal_ra: got %0b want 0", jal_ra); end
    tests++; if (wr_out !== 5'd0) begin fails++; $display("FAIL reset_wr_out: got %0d want 0", wr_out); end
    tests++; if (write_data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", write_data_out); end
    tests++; if (in_ready !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got ready=%0b stall=%0b want 0/1", in_ready, stall); end
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL post_reset_ready: got ready=%0b stall=%0b want 1/0", in_ready, stall); end
  endtask

  task automatic test_alu();
    set_alu(5'd8, 32'h0000_1234);
    tick();
    idle_inputs();
    tests++; if (regwrite !== 1'b1) begin fails++; $display("FAIL alu_regwrite: got %0b want 1", regwrite); end
    tests++; if (wr_out !== 5'd8) begin fails++; $display("FAIL alu_wr_out: got %0d want 8", wr_out); end
    tests++; if (write_data_out !== 32'h0000_1234) begin fails++; $display("FAIL alu_data: got %h want 00001234", write_data_out); end
    tests++; if (jal_ra !== 1'b0) begin fails++; $display("FAIL alu_jal_ra: got %0b want 0", jal_ra); end
    tick();
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL alu_regwrite_clear: got %0b want 0", regwrite); end
  endtask

  task automatic test_zero_reg();
    set_alu(5'd0, 32'h0000_ABCD);
    tick();
    idle_inputs();
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL zero_reg_regwrite: got %0b want 0", regwrite); end
    tests++; if (write_data_out !== 32'h0000_ABCD) begin fails++; $display("FAIL zero_reg_data: got %h want 0000abcd", write_data_out); end
    tick();
  endtask

  task automatic test_signed_byte();
    set_load(5'd9, 2'd3, 2'b00, 1'b0);
    // rvalid in the transfer cycle itself must be ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL byte_wait_ready[%0d]: got %0b want 0", i, in_ready); end
      tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL byte_wait_regwrite[%0d]: got %0b want 0", i, regwrite); end
      if (i == 2) begin dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0011; end
      tick();
    end
    dmem_rvalid = 1'b0;
    tests++; if (regwrite !== 1'b1) begin fails++; $display("FAIL byte_regwrite: got %0b want 1", regwrite); end
    tests++; if (wr_out !== 5'd9) begin fails++; $display("FAIL byte_wr_out: got %0d want 9", wr_out); end
    tests++; if (write_data_out !== 32'hFFFF_FF80) begin fails++; $display("FAIL byte_data: got %h want ffffff80", write_data_out); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL byte_ready_after: got %0b want 1", in_ready); end
    tick();
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL byte_regwrite_clear: got %0b want 0", regwrite); end
  endtask

  task automatic test_load_formats();
    logic [1:0]  offs  [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd1};
    logic [1:0]  sizes [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    logic        unss  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] rdat  [5] = '{32'hBEEF_1234, 32'hBEEF_1234, 32'h80FF_0011, 32'h0000_F000, 32'h89AB_CDEF};
    logic [31:0] exp   [5] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0011, 32'hFFFF_FFF0, 32'h89AB_CDEF};
    for (int k = 0; k < 5; k++) begin
      set_load(5'd10 + 5'(k), offs[k], sizes[k], unss[k]);
      tick();
      idle_inputs();
      dmem_rvalid = 1'b1; dmem_rdata = rdat[k];
      tick();
      dmem_rvalid = 1'b0;
      tests++; if (regwrite !== 1'b1 || wr_out !== 5'd10 + 5'(k)) begin fails++; $display("FAIL fmt_write[%0d]: got rw=%0b wr=%0d want 1/%0d", k, regwrite, wr_out, 10 + k); end
      tests++; if (write_data_out !== exp[k]) begin fails++; $display("FAIL fmt_data[%0d]: got %h want %h", k, write_data_out, exp[k]); end
      tick();
    end
  endtask

  task automatic test_jal();
    in_valid = 1'b1; jal_in = 1'b1; memtoreg_in = 1'b1; regwrite_in = 1'b1;
    wr_in = 5'd0; pc_plus4_in = 32'h0040_0010; alu_result_in = 32'h0000_0003;
    tick();
    idle_inputs();
    tests++; if (regwrite !== 1'b1 || jal_ra !== 1'b1) begin fails++; $display("FAIL jal_flags: got rw=%0b ra=%0b want 1/1", regwrite, jal_ra); end
    tests++; if (wr_out !== 5'd31) begin fails++; $display("FAIL jal_wr_out: got %0d want 31", wr_out); end
    tests++; if (write_data_out !== 32'h0040_0010) begin fails++; $display("FAIL jal_data: got %h want 00400010", write_data_out); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL jal_not_load: got %0b want 1", in_ready); end
    tick();
    tests++; if (regwrite !== 1'b0 || jal_ra !== 1'b0) begin fails++; $display("FAIL jal_clear: got rw=%0b ra=%0b want 0/0", regwrite, jal_ra); end
  endtask

  task automatic test_back_to_back();
    set_alu(5'd5, 32'h0000_0005);
    tick();
    tests++; if (regwrite !== 1'b1 || wr_out !== 5'd5 || write_data_out !== 32'h5) begin fails++; $display("FAIL b2b_0: got rw=%0b wr=%0d d=%h want 1/5/5", regwrite, wr_out, write_data_out); end
    set_alu(5'd6, 32'h0000_0006);
    tick();
    tests++; if (regwrite !== 1'b1 || wr_out !== 5'd6 || write_data_out !== 32'h6) begin fails++; $display("FAIL b2b_1: got rw=%0b wr=%0d d=%h want 1/6/6", regwrite, wr_out, write_data_out); end
    set_alu(5'd7, 32'h0000_0007);
    tick();
    tests++; if (regwrite !== 1'b1 || wr_out !== 5'd7 || write_data_out !== 32'h7) begin fails++; $display("FAIL b2b_2: got rw=%0b wr=%0d d=%h want 1/7/7", regwrite, wr_out, write_data_out); end
    idle_inputs();
    tick();
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL b2b_end: got %0b want 0", regwrite); end
  endtask

  task automatic test_reset_mid_load();
    set_load(5'd12, 2'd0, 2'b10, 1'b0);
    tick();
    idle_inputs();
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midload_waiting: got %0b want 0", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midload_ready: got %0b want 1", in_ready); end
    tick();
    dmem_rvalid = 1'b0;
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL midload_regwrite0: got %0b want 0", regwrite); end
    tick();
    tests++; if (regwrite !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midload_regwrite1: got rw=%0b ready=%0b want 0/1", regwrite, in_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_zero_reg();
    test_signed_byte();
    test_load_formats();
    test_jal();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
